// File: rtl/mode_pkg.sv
// Shared definitions for the mode router: mode indices, BCD converter states
// and the circular enabled-mode search helpers.
package mode_pkg;

    localparam int MODE_BOX   = 0;
    localparam int MODE_ORGAN = 1;
    localparam int MODE_WRITE = 2;
    localparam int MODE_METRO = 3;

    // Search helpers work on a fixed 8-entry mask; callers zero-extend.
    localparam int MAX_MODES = 8;

    typedef enum logic [1:0] {
        BCD_IDLE  = 2'd0,
        BCD_SHIFT = 2'd1,
        BCD_DONE  = 2'd2
    } bcd_state_t;

    // First enabled mode above cur (wrapping within n); cur if none other is enabled.
    function automatic logic [2:0] next_enabled(input logic [2:0] cur,
                                                input logic [7:0] en,
                                                input int         n);
        logic [2:0] res;
        logic [2:0] idx3;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i < MAX_MODES; i++) begin
            if (i < n && !found) begin
                idx3 = 3'((int'(cur) + i) % n);
                if (en[idx3]) begin
                    res   = idx3;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // First enabled mode below cur (wrapping within n); cur if none other is enabled.
    function automatic logic [2:0] prev_enabled(input logic [2:0] cur,
                                                input logic [7:0] en,
                                                input int         n);
        logic [2:0] res;
        logic [2:0] idx3;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i < MAX_MODES; i++) begin
            if (i < n && !found) begin
                idx3 = 3'((int'(cur) + n - i) % n);
                if (en[idx3]) begin
                    res   = idx3;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mode_router_bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, one shift
// per cycle). The result register holds the last completed conversion.
module bin2bcd_seq
    import mode_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    bcd_state_t  state, state_nx;
    logic [19:0] sr;
    logic [2:0]  cnt;

    // Add-3 adjust on every BCD digit >= 5, then shift the whole register left.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int d = 0; d < 3; d++) begin
            if (t[8 + 4*d +: 4] >= 4'd5)
                t[8 + 4*d +: 4] = t[8 + 4*d +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BCD_IDLE;
        else        state <= state_nx;
    end

    // Next-state: eight shifts, one result cycle, back to idle.
    always_comb begin
        state_nx = state;
        case (state)
            BCD_IDLE:  if (start) state_nx = BCD_SHIFT;
            BCD_SHIFT: if (cnt == 3'd7) state_nx = BCD_DONE;
            BCD_DONE:  state_nx = BCD_IDLE;
            default:   state_nx = BCD_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state == BCD_SHIFT);
        done = (state == BCD_DONE);
    end

    // Shift register, shift counter and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
            bcd <= '0;
        end else begin
            case (state)
                BCD_IDLE: begin
                    if (start) begin
                        sr  <= {12'd0, bin};
                        cnt <= '0;
                    end
                end
                BCD_SHIFT: begin
                    sr  <= dd_step(sr);
                    cnt <= cnt + 3'd1;
                end
                BCD_DONE: bcd <= sr[19:8];
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mode_router.sv
// Active-mode holder and channel router: steps through enabled modes, mutes
// audio and panel pulses for a fixed window after each change, and registers
// the selected channel's LED/display/audio onto the front-panel outputs.
module mode_router
    import mode_pkg::*;
#(
    parameter int NUM_MODES   = 4,
    parameter int LED_W       = 16,
    parameter int DISP_W      = 32,
    parameter int MUTE_CYCLES = 1024,
    parameter int BCD_MODE    = MODE_METRO
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mode_next,
    input  logic                          mode_prev,
    input  logic [NUM_MODES-1:0]          mode_en,
    input  logic                          inc,
    input  logic                          dec,
    input  logic [7:0]                    speed,
    input  logic [NUM_MODES*LED_W-1:0]    ch_led,
    input  logic [NUM_MODES*DISP_W-1:0]   ch_disp,
    input  logic [NUM_MODES-1:0]          ch_audio,
    input  logic [NUM_MODES-1:0]          ch_en,
    output logic [$clog2(NUM_MODES)-1:0]  mode,
    output logic [NUM_MODES-1:0]          mode_oh,
    output logic [NUM_MODES-1:0]          inc_out,
    output logic [NUM_MODES-1:0]          dec_out,
    output logic [LED_W-1:0]              led,
    output logic [DISP_W-1:0]             disp,
    output logic                          bell,
    output logic                          en,
    output logic                          switching
);

    localparam int              MW        = $clog2(NUM_MODES);
    localparam int              CW        = $clog2(MUTE_CYCLES + 1);
    localparam logic [CW-1:0]   MUTE_LOAD = CW'(MUTE_CYCLES);
    localparam logic [MW-1:0]   BCD_IDX   = MW'(BCD_MODE);

    logic [CW-1:0]        mute_cnt, mute_d;
    logic [MW-1:0]        mode_d, cand;
    logic                 step_fwd, step_bwd, mode_chg;
    logic [7:0]           last_speed;
    logic                 bcd_start, bcd_busy, bcd_done;
    logic [11:0]          bcd_val;
    logic [LED_W-1:0]     led_d;
    logic [DISP_W-1:0]    disp_d;
    logic                 bell_d, en_d;
    logic [NUM_MODES-1:0] inc_d, dec_d;

    // Mode step decision and mute counter next value; steps are ignored while muted.
    always_comb begin
        step_fwd = mode_next & ~mode_prev & ~switching;
        step_bwd = mode_prev & ~mode_next & ~switching;
        if (step_fwd)
            cand = MW'(next_enabled(3'(mode), 8'(mode_en), NUM_MODES));
        else
            cand = MW'(prev_enabled(3'(mode), 8'(mode_en), NUM_MODES));
        mode_chg = (step_fwd | step_bwd) && (cand != mode);
        mode_d   = mode_chg ? cand : mode;
        if (mode_chg)
            mute_d = MUTE_LOAD;
        else if (mute_cnt != '0)
            mute_d = mute_cnt - CW'(1);
        else
            mute_d = mute_cnt;
    end

    // Active mode and mute counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode     <= '0;
            mute_cnt <= MUTE_LOAD;
        end else begin
            mode     <= mode_d;
            mute_cnt <= mute_d;
        end
    end

    assign switching = (mute_cnt != '0);

    // One-hot view of the active mode.
    always_comb begin
        mode_oh       = '0;
        mode_oh[mode] = 1'b1;
    end

    // A new conversion starts only from idle; a change seen mid-run waits for the next one.
    assign bcd_start = ~bcd_busy & ~bcd_done & (speed != last_speed);

    // Remember the value handed to the converter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         last_speed <= '0;
        else if (bcd_start) last_speed <= speed;
    end

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (bcd_start),
        .bin   (last_speed == speed ? last_speed : speed),
        .busy  (bcd_busy),
        .done  (bcd_done),
        .bcd   (bcd_val)
    );

    // Channel selection for the upcoming mode; muted cycles silence audio and pulses.
    always_comb begin
        led_d  = ch_led[int'(mode_d)*LED_W +: LED_W];
        disp_d = ch_disp[int'(mode_d)*DISP_W +: DISP_W];
        if (mode_d == BCD_IDX)
            disp_d[11:0] = bcd_val;
        bell_d = 1'b0;
        en_d   = 1'b0;
        inc_d  = '0;
        dec_d  = '0;
        if (mute_d == '0) begin
            bell_d        = ch_audio[mode_d];
            en_d          = ch_en[mode_d];
            inc_d[mode_d] = inc;
            dec_d[mode_d] = dec;
        end
    end

    // Registered routed outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led     <= '0;
            disp    <= '0;
            bell    <= 1'b0;
            en      <= 1'b0;
            inc_out <= '0;
            dec_out <= '0;
        end else begin
            led     <= led_d;
            disp    <= disp_d;
            bell    <= bell_d;
            en      <= en_d;
            inc_out <= inc_d;
            dec_out <= dec_d;
        end
    end

endmodule

// File: tb/tb_mode_router.sv
module tb_mode_router;

    localparam int NM   = 4;
    localparam int LW   = 16;
    localparam int DW   = 32;
    localparam int MUTE = 8;

    localparam int S_MODE = 0;
    localparam int S_OH   = 1;
    localparam int S_SW   = 2;
    localparam int S_INC  = 3;
    localparam int S_DEC  = 4;
    localparam int S_BELL = 5;
    localparam int S_EN   = 6;
    localparam int S_LED  = 7;
    localparam int S_DISP = 8;
    localparam int S_BCD  = 9;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mode_next, mode_prev, inc, dec;
    logic [NM-1:0]    mode_en;
    logic [7:0]       speed;
    logic [NM*LW-1:0] ch_led;
    logic [NM*DW-1:0] ch_disp;
    logic [NM-1:0]    ch_audio, ch_en;
    logic [1:0]       mode;
    logic [NM-1:0]    mode_oh, inc_out, dec_out;
    logic [LW-1:0]    led;
    logic [DW-1:0]    disp;
    logic             bell, en, switching;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    mode_router #(
        .NUM_MODES   (NM),
        .LED_W       (LW),
        .DISP_W      (DW),
        .MUTE_CYCLES (MUTE),
        .BCD_MODE    (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_next (mode_next),
        .mode_prev (mode_prev),
        .mode_en   (mode_en),
        .inc       (inc),
        .dec       (dec),
        .speed     (speed),
        .ch_led    (ch_led),
        .ch_disp   (ch_disp),
        .ch_audio  (ch_audio),
        .ch_en     (ch_en),
        .mode      (mode),
        .mode_oh   (mode_oh),
        .inc_out   (inc_out),
        .dec_out   (dec_out),
        .led       (led),
        .disp      (disp),
        .bell      (bell),
        .en        (en),
        .switching (switching)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            S_MODE:  return 32'(mode);
            S_OH:    return 32'(mode_oh);
            S_SW:    return 32'(switching);
            S_INC:   return 32'(inc_out);
            S_DEC:   return 32'(dec_out);
            S_BELL:  return 32'(bell);
            S_EN:    return 32'(en);
            S_LED:   return 32'(led);
            S_DISP:  return disp;
            S_BCD:   return 32'(disp[11:0]);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        int          i;
        logic [31:0] act;
        i = 0;
        while (i < sbq.size()) begin
            if (sbq[i].cyc <= cyc) begin
                checks++;
                act = probe(sbq[i].sel);
                if (sbq[i].cyc < cyc || act !== sbq[i].val) begin
                    failures++;
                    $display("FAIL %s cyc=%0d actual=%h required=%h",
                             sbq[i].name, sbq[i].cyc, act, sbq[i].val);
                end
                sbq.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int d, input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + d;
        e.sel  = sel;
        e.val  = v;
        e.name = nm;
        sbq.push_back(e);
    endtask

    // One-cycle step pulse; moves says whether a mode change (and mute) must follow.
    task automatic step(input bit nxt, input bit prv, input int m, input bit moves);
        mode_next = nxt;
        mode_prev = prv;
        push_exp(1, S_MODE, 32'(m), "step_mode");
        push_exp(1, S_OH, 32'(1) << m, "step_mode_oh");
        if (moves) begin
            push_exp(1, S_SW, 32'd1, "mute_rise");
            push_exp(MUTE, S_SW, 32'd1, "mute_last");
            push_exp(MUTE + 1, S_SW, 32'd0, "mute_fall");
        end else begin
            push_exp(1, S_SW, 32'd0, "no_mute");
        end
        tick();
        mode_next = 1'b0;
        mode_prev = 1'b0;
    endtask

    initial begin
        int seq[5];
        seq = '{1, 2, 3, 0, 1};
        rst_n     = 1'b0;
        mode_next = 1'b0;
        mode_prev = 1'b0;
        inc       = 1'b0;
        dec       = 1'b0;
        speed     = 8'd0;
        mode_en   = 4'b1111;
        ch_led    = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        ch_disp   = {32'hCAFE_F123, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
        ch_audio  = 4'b0101;
        ch_en     = 4'b0101;

        // Reset values
        tick();
        checks++;
        if (mode !== 2'd0) begin
            failures++;
            $display("FAIL direct_rst_mode actual=%h required=%h", mode, 2'd0);
        end
        checks++;
        if (switching !== 1'b1) begin
            failures++;
            $display("FAIL direct_rst_switching actual=%b required=%b", switching, 1'b1);
        end
        checks++;
        if (mode_oh !== 4'b0001) begin
            failures++;
            $display("FAIL direct_rst_mode_oh actual=%b required=%b", mode_oh, 4'b0001);
        end
        push_exp(0, S_MODE, 32'd0, "rst_mode");
        push_exp(0, S_OH, 32'd1, "rst_mode_oh");
        push_exp(0, S_SW, 32'd1, "rst_switching");
        push_exp(0, S_BELL, 32'd0, "rst_bell");
        push_exp(0, S_EN, 32'd0, "rst_en");
        push_exp(0, S_LED, 32'd0, "rst_led");
        push_exp(0, S_DISP, 32'd0, "rst_disp");
        push_exp(0, S_INC, 32'd0, "rst_inc_out");
        tick();
        rst_n = 1'b1;
        push_exp(MUTE - 1, S_SW, 32'd1, "rst_mute_last");
        push_exp(MUTE, S_SW, 32'd0, "rst_mute_fall");
        repeat (MUTE + 2) tick();
        push_exp(0, S_LED, 32'h1111, "led_mode0");
        push_exp(0, S_DISP, 32'hDEAD_BEEF, "disp_mode0");

        // Five forward steps with all modes enabled
        for (int k = 0; k < 5; k++) begin
            if (seq[k] == 3) push_exp(1, S_DISP, 32'hCAFE_F000, "disp_bcd_zero");
            push_exp(1, S_LED, 32'h1111 * (seq[k] + 1), "led_route");
            step(1'b1, 1'b0, seq[k], 1'b1);
            repeat (MUTE + 1) tick();
        end

        // Masked stepping
        mode_en = 4'b1010;
        step(1'b1, 1'b0, 3, 1'b1);
        repeat (MUTE + 1) tick();
        mode_en = 4'b0010;
        step(1'b1, 1'b0, 1, 1'b1);
        repeat (MUTE + 1) tick();
        push_exp(1, S_SW, 32'd0, "lone_mode_no_mute2");
        step(1'b1, 1'b0, 1, 1'b0);
        repeat (2) tick();

        // Backward step, simultaneous pulses, pulse during mute
        mode_en = 4'b1111;
        step(1'b0, 1'b1, 0, 1'b1);
        repeat (MUTE + 1) tick();
        step(1'b1, 1'b1, 0, 1'b0);
        tick();
        step(1'b1, 1'b0, 1, 1'b1);
        tick();
        mode_next = 1'b1;
        push_exp(1, S_MODE, 32'd1, "drop_during_mute");
        tick();
        mode_next = 1'b0;
        repeat (MUTE) tick();

        // Steering and audio muting in mode 2
        step(1'b1, 1'b0, 2, 1'b1);
        tick();
        inc = 1'b1;
        push_exp(1, S_INC, 32'd0, "inc_in_mute");
        push_exp(1, S_BELL, 32'd0, "bell_in_mute");
        push_exp(1, S_EN, 32'd0, "en_in_mute");
        tick();
        inc = 1'b0;
        repeat (MUTE) tick();
        push_exp(0, S_BELL, 32'd1, "bell_after_mute");
        push_exp(0, S_EN, 32'd1, "en_after_mute");
        inc = 1'b1;
        push_exp(1, S_INC, 32'b0100, "inc_steer");
        push_exp(2, S_INC, 32'd0, "inc_one_cycle");
        tick();
        inc = 1'b0;
        tick();
        dec = 1'b1;
        push_exp(1, S_DEC, 32'b0100, "dec_steer");
        push_exp(1, S_INC, 32'd0, "inc_idle");
        tick();
        dec = 1'b0;
        tick();

        // BCD formatting in mode 3
        step(1'b1, 1'b0, 3, 1'b1);
        repeat (MUTE + 1) tick();
        speed = 8'd207;
        push_exp(11, S_BCD, 32'h207, "bcd_207");
        push_exp(11, S_DISP, 32'hCAFE_F207, "disp_bcd_207");
        repeat (14) tick();
        speed = 8'd45;
        push_exp(11, S_BCD, 32'h045, "bcd_045");
        repeat (14) tick();
        speed = 8'd99;
        push_exp(11, S_BCD, 32'h099, "bcd_099");
        repeat (2) tick();
        speed = 8'd150;
        push_exp(19, S_BCD, 32'h150, "bcd_150_queued");
        repeat (22) tick();
        ch_led[3*LW +: LW] = 16'hABCD;
        push_exp(1, S_LED, 32'hABCD, "led_follows_input");
        tick();

        // Back to mode 0: display passes through unmodified
        push_exp(1, S_DISP, 32'hDEAD_BEEF, "disp_mode0_raw");
        step(1'b1, 1'b0, 0, 1'b1);
        repeat (MUTE + 1) tick();
        push_exp(0, S_BELL, 32'd1, "bell_mode0");

        // Reset while muted and converting
        mode_next = 1'b1;
        speed     = 8'd77;
        push_exp(1, S_MODE, 32'd1, "pre_reset_step");
        tick();
        mode_next = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        push_exp(0, S_MODE, 32'd0, "arst_mode");
        push_exp(0, S_OH, 32'd1, "arst_mode_oh");
        push_exp(0, S_SW, 32'd1, "arst_switching");
        push_exp(0, S_BELL, 32'd0, "arst_bell");
        push_exp(0, S_BCD, 32'd0, "arst_disp_low");
        push_exp(0, S_LED, 32'd0, "arst_led");
        tick();
        checks++;
        if (mode !== 2'd0) begin
            failures++;
            $display("FAIL direct_arst_mode actual=%h required=%h", mode, 2'd0);
        end
        checks++;
        if (switching !== 1'b1) begin
            failures++;
            $display("FAIL direct_arst_switching actual=%b required=%b", switching, 1'b1);
        end
        checks++;
        if (bell !== 1'b0) begin
            failures++;
            $display("FAIL direct_arst_bell actual=%b required=%b", bell, 1'b0);
        end
        rst_n = 1'b1;
        repeat (3) tick();

        foreach (sbq[i]) begin
            checks++;
            failures++;
            $display("FAIL %s cyc=%0d actual=unchecked required=%h", sbq[i].name, sbq[i].cyc, sbq[i].val);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mode_router.md
# mode_router

Parametrised successor to the music-box mode controller. Holds the active operating mode (music box, electone, writing, metronome, …), steers the front-panel inc/dec pulses to the active channel only, and drives registered LED, display, audio and digit-enable outputs from that channel. A mute window on every mode change gives glitch-free switching. A sequential binary-to-BCD converter formats the tempo value for the display.

## Interface
Parameters:
- NUM_MODES, 4: number of channels/modes, 2..8.
- LED_W, 16: LED bus width per channel.
- DISP_W, 32: display data width per channel, at least 12.
- MUTE_CYCLES, 1024: cycles of forced silence after a mode change, at least 1.
- BCD_MODE, 3: mode whose display low 12 bits are replaced by BCD of `speed`.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- mode_next  in  1  debounced single-cycle pulse: advance mode.
- mode_prev  in  1  debounced single-cycle pulse: step mode back.
- mode_en  in  NUM_MODES  per-mode enable mask; disabled modes are skipped.
- inc, dec  in  1 each  debounced single-cycle pulses from the panel.
- speed  in  8  tempo, 0..255.
- ch_led  in  NUM_MODES*LED_W  per-channel LED data; channel k occupies bits [k*LED_W +: LED_W].
- ch_disp  in  NUM_MODES*DISP_W  per-channel display data, packed the same way.
- ch_audio  in  NUM_MODES  per-channel audio bit.
- ch_en  in  NUM_MODES  per-channel audio enable.
- mode  out  $clog2(NUM_MODES)  active mode index.
- mode_oh  out  NUM_MODES  one-hot form of `mode`.
- inc_out, dec_out  out  NUM_MODES each  steered pulses.
- led  out  LED_W  routed LED data.
- disp  out  DISP_W  routed display data.
- bell  out  1  routed audio.
- en  out  1  routed audio enable.
- switching  out  1  high during the mute window.

## Operation
- Reset values:
  - mode = 0 and mode_oh = 1, regardless of the `mode_en` mask.
  - switching = 1, with the mute counter loaded to MUTE_CYCLES.
  - All other outputs 0.
  - BCD converter idle, with its result register cleared to 0.
- Mode stepping:
  - `mode_next` searches upward, wrapping from NUM_MODES-1 to 0, for the first enabled mode other than the current one.
  - `mode_prev` searches downward the same way.
  - If no other mode is enabled, `mode` is unchanged and no mute is triggered.
  - If the current mode becomes disabled, it stays active until the next step.
- Simultaneous `mode_next` and `mode_prev`: both are ignored.
- Step pulses arriving while `switching` = 1 are dropped.
- Every mode change reloads the mute counter.
- Mute window (`switching` = 1):
  - `bell` and `en` are forced to 0.
  - `inc_out` and `dec_out` are forced to 0.
  - `led` and `disp` still follow the new mode.
- Steering: `inc_out[mode]` = `inc`, and `dec_out[mode]` = `dec`. All other bits are 0, so there are no latched or stale assignments.
- Display:
  - When mode == BCD_MODE: disp = {ch_disp upper bits, hundreds[3:0], tens[3:0], ones[3:0]}.
  - Otherwise `disp` is the channel value unmodified.
- BCD converter: double-dabble, one shift per cycle.
  - States IDLE -> SHIFT (8 cycles) -> DONE (1 cycle, result registered) -> IDLE.
  - A conversion starts in IDLE whenever `speed` differs from the last converted value.
  - A `speed` change mid-conversion is picked up by the next conversion; the running one is never aborted.

## Timing
- Mode step pulse at cycle t: `mode`, `mode_oh` and `switching` update at t+1.
- `switching` stays high for exactly MUTE_CYCLES cycles, t+1 .. t+MUTE_CYCLES, then falls.
- All routed outputs (led, disp, bell, en, inc_out, dec_out) are registered: 1-cycle latency from channel inputs or pulses.
- `inc` pulse at t: `inc_out[mode]` high at t+1, for one cycle only.
- BCD latency: `speed` change at t -> new BCD visible on `disp` by t+11 in the worst case, with the converter idle.
- Asynchronous reset mid-mute or mid-conversion returns everything to the reset values immediately.

## Structure
- Package `mode_pkg` holds:
  - Mode index localparams: MODE_BOX=0, MODE_ORGAN=1, MODE_WRITE=2, MODE_METRO=3.
  - BCD state enum.
  - A `next_enabled` / `prev_enabled` search function.
- One sub-module, `bin2bcd_seq` (8-bit in, 12-bit out, start/busy/done), instantiated once.
- Everything else lives in `mode_router`.

## Test plan
- Reset, then `mode_next` ×5 with mask 4'b1111 -> mode 1,2,3,0,1. `switching` is high for MUTE_CYCLES after each step (bench uses MUTE_CYCLES=8).
- Mask 4'b1010 from mode 1, `mode_next` -> mode 3. Mask 4'b0010, `mode_next` -> mode stays 1 and `switching` stays low.
- `mode_next` and `mode_prev` in the same cycle -> no change. A step pulse during the mute window -> dropped.
- Mode 2 after mute: `inc` pulse -> inc_out = 4'b0100 for one cycle. Same pulse during mute -> inc_out = 0. ch_audio[2]=1 -> bell=0 during mute, 1 after.
- Mode 3, speed = 8'd207 -> disp[11:0] = 12'h207 within 11 cycles. Then speed = 8'd45 -> 12'h045. Mode 0 -> disp equals ch_disp[31:0] unmodified.
- Assert `rst_n` mid-conversion and mid-mute -> mode 0, switching 1, bell 0, disp low bits 0 immediately.
